// File: rtl/card_flip_pkg.sv
// Shared constants and state encoding for the card-flip game blocks
// (controller, elapsed-time counter/HEX display, board renderer).
package card_flip_pkg;

  localparam int unsigned NUM_CARDS = 16;
  localparam int unsigned NUM_PAIRS = 8;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned VAL_W     = 3;
  localparam int unsigned PAIR_W    = 4;
  localparam int unsigned MISM_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FIRST   = 3'd1,
    ST_SECOND  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_SHOW    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // States in which a player selection may be accepted.
  function automatic logic is_select_state(input state_e s);
    return (s == ST_IDLE) || (s == ST_FIRST) || (s == ST_SECOND);
  endfunction

endpackage

// File: rtl/card_flip_ctrl_if.sv
// Player/deck inputs and board/status outputs of the card-flip controller.
// Inputs are sampled on clk; outputs are driven from registers only.
interface card_flip_ctrl_if;
  import card_flip_pkg::*;

  logic                 new_game;
  logic                 deck_wr;
  logic [IDX_W-1:0]     deck_wr_idx;
  logic [VAL_W-1:0]     deck_wr_val;
  logic                 select_valid;
  logic [IDX_W-1:0]     select_idx;
  logic [NUM_CARDS-1:0] face_up;
  logic [NUM_CARDS-1:0] matched;
  logic                 game_start;
  logic                 game_end;
  logic [PAIR_W-1:0]    pairs_found;
  logic [MISM_W-1:0]    mismatches;
  logic                 busy;

  // Selections are single-cycle strobes with no backpressure: select_valid is
  // taken only when busy is low and the card is hidden, otherwise dropped.
  modport master (
    output new_game, deck_wr, deck_wr_idx, deck_wr_val, select_valid, select_idx,
    input  face_up, matched, game_start, game_end, pairs_found, mismatches, busy
  );

  modport slave (
    input  new_game, deck_wr, deck_wr_idx, deck_wr_val, select_valid, select_idx,
    output face_up, matched, game_start, game_end, pairs_found, mismatches, busy
  );

endinterface

// File: rtl/card_flip_hold_timer.sv
// Down-counter holding a mismatched pair face-up; expire_o is high during the
// last of SHOW_CYCLES counted cycles after a load.
module card_flip_hold_timer #(
  parameter int unsigned SHOW_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic load_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(SHOW_CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(SHOW_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/card_flip_ctrl.sv
// Card-flip game controller: deck storage, pair reveal/compare FSM, match and
// mismatch counting, and game_start/game_end pulses for the timer display.
module card_flip_ctrl
  import card_flip_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  card_flip_ctrl_if.slave  bus,
  output state_e           state_o
);

  state_e               state_q, state_d;
  logic [NUM_CARDS-1:0] face_up_q, face_up_d;
  logic [NUM_CARDS-1:0] matched_q, matched_d;
  logic [IDX_W-1:0]     first_q, first_d;
  logic [IDX_W-1:0]     second_q, second_d;
  logic [PAIR_W-1:0]    pairs_q, pairs_d;
  logic [MISM_W-1:0]    mism_q, mism_d;
  logic                 start_q, start_d;
  logic                 end_q, end_d;
  logic                 timer_load, timer_clear, timer_expire;
  logic                 sel_ok;
  logic                 deck_wr_ok;
  logic [VAL_W-1:0]     deck_q [NUM_CARDS];

  // The deck survives reset and new_game so a board can be replayed.
  assign deck_wr_ok = bus.deck_wr && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_ff @(posedge clk) begin
    if (reset && deck_wr_ok) begin
      deck_q[bus.deck_wr_idx] <= bus.deck_wr_val;
    end
  end

  assign sel_ok = bus.select_valid && is_select_state(state_q) &&
                  !face_up_q[bus.select_idx] && !matched_q[bus.select_idx];

  card_flip_hold_timer #(
    .SHOW_CYCLES (SHOW_CYCLES)
  ) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (timer_clear),
    .load_i   (timer_load),
    .expire_o (timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    face_up_d   = face_up_q;
    matched_d   = matched_q;
    first_d     = first_q;
    second_d    = second_q;
    pairs_d     = pairs_q;
    mism_d      = mism_q;
    start_d     = 1'b0;
    end_d       = 1'b0;
    timer_load  = 1'b0;
    timer_clear = 1'b0;

    // new_game overrides any selection or compare result in the same cycle.
    if (bus.new_game) begin
      state_d     = ST_IDLE;
      face_up_d   = '0;
      matched_d   = '0;
      pairs_d     = '0;
      mism_d      = '0;
      timer_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_FIRST: begin
          if (sel_ok) begin
            face_up_d[bus.select_idx] = 1'b1;
            first_d = bus.select_idx;
            state_d = ST_SECOND;
            start_d = (state_q == ST_IDLE);
          end
        end
        ST_SECOND: begin
          if (sel_ok) begin
            face_up_d[bus.select_idx] = 1'b1;
            second_d = bus.select_idx;
            state_d  = ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (deck_q[first_q] == deck_q[second_q]) begin
            face_up_d[first_q]  = 1'b0;
            face_up_d[second_q] = 1'b0;
            matched_d[first_q]  = 1'b1;
            matched_d[second_q] = 1'b1;
            pairs_d = pairs_q + PAIR_W'(1);
            if (pairs_d == PAIR_W'(NUM_PAIRS)) begin
              end_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_FIRST;
            end
          end else begin
            if (mism_q != '1) begin
              mism_d = mism_q + MISM_W'(1);
            end
            timer_load = 1'b1;
            state_d    = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (timer_expire) begin
            face_up_d[first_q]  = 1'b0;
            face_up_d[second_q] = 1'b0;
            state_d = ST_FIRST;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      face_up_q <= '0;
      matched_q <= '0;
      first_q   <= '0;
      second_q  <= '0;
      pairs_q   <= '0;
      mism_q    <= '0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      face_up_q <= face_up_d;
      matched_q <= matched_d;
      first_q   <= first_d;
      second_q  <= second_d;
      pairs_q   <= pairs_d;
      mism_q    <= mism_d;
      start_q   <= start_d;
      end_q     <= end_d;
    end
  end

  assign bus.face_up     = face_up_q;
  assign bus.matched     = matched_q;
  assign bus.game_start  = start_q;
  assign bus.game_end    = end_q;
  assign bus.pairs_found = pairs_q;
  assign bus.mismatches  = mism_q;
  assign bus.busy        = (state_q == ST_COMPARE) || (state_q == ST_SHOW);
  assign state_o         = state_q;

endmodule

// File: tb/tb_card_flip_ctrl.sv
// Directed bench for card_flip_ctrl with a short mismatch hold time.
module tb_card_flip_ctrl;
  import card_flip_pkg::*;

  localparam int unsigned SHOW = 4;

  logic   clk;
  logic   reset;
  state_e dbg_state;
  int     n_cmp;
  int     n_fail;

  card_flip_ctrl_if bus();

  card_flip_ctrl #(
    .SHOW_CYCLES (SHOW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change after the falling edge, outputs are
  // inspected at the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sel(input logic [3:0] idx);
    bus.select_valid = 1'b1;
    bus.select_idx   = idx;
    step();
    bus.select_valid = 1'b0;
  endtask

  task automatic deck_write(input logic [3:0] idx, input logic [2:0] val);
    bus.deck_wr     = 1'b1;
    bus.deck_wr_idx = idx;
    bus.deck_wr_val = val;
    step();
    bus.deck_wr     = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_face"},  32'(bus.face_up),     32'h0);
    chk({tag, "_match"}, 32'(bus.matched),     32'h0);
    chk({tag, "_start"}, 32'(bus.game_start),  32'h0);
    chk({tag, "_end"},   32'(bus.game_end),    32'h0);
    chk({tag, "_pairs"}, 32'(bus.pairs_found), 32'h0);
    chk({tag, "_mism"},  32'(bus.mismatches),  32'h0);
    chk({tag, "_busy"},  32'(bus.busy),        32'h0);
    chk({tag, "_state"}, 32'(dbg_state),       32'(ST_IDLE));
  endtask

  // One full mismatch: two selections, compare cycle, SHOW hold.
  task automatic do_mismatch(input logic [3:0] a, input logic [3:0] b);
    sel(a);
    sel(b);
    step();
    repeat (SHOW) step();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset            = 1'b0;
    bus.new_game     = 1'b0;
    bus.deck_wr      = 1'b0;
    bus.deck_wr_idx  = '0;
    bus.deck_wr_val  = '0;
    bus.select_valid = 1'b0;
    bus.select_idx   = '0;

    // Reset state
    step();
    step();
    chk_idle_zero("reset");
    reset = 1'b1;
    step();

    // Deck {0,0,1,1,...,7,7}
    for (int i = 0; i < 16; i++) deck_write(4'(i), 3'(i / 2));
    chk_idle_zero("after_deck");

    // First pair: select 0 then 1
    sel(4'd0);
    chk("sel0_face",  32'(bus.face_up),    32'h0001);
    chk("sel0_start", 32'(bus.game_start), 32'h1);
    chk("sel0_state", 32'(dbg_state),      32'(ST_SECOND));
    step();
    chk("start_one_cycle", 32'(bus.game_start), 32'h0);
    sel(4'd1);
    chk("sel1_face",  32'(bus.face_up), 32'h0003);
    chk("sel1_state", 32'(dbg_state),   32'(ST_COMPARE));
    chk("sel1_busy",  32'(bus.busy),    32'h1);
    step();
    chk("pair0_match", 32'(bus.matched),     32'h0003);
    chk("pair0_face",  32'(bus.face_up),     32'h0000);
    chk("pair0_pairs", 32'(bus.pairs_found), 32'h1);
    chk("pair0_state", 32'(dbg_state),       32'(ST_FIRST));
    chk("pair0_busy",  32'(bus.busy),        32'h0);

    // Invalid selections and a deck write during play
    sel(4'd0);
    chk("sel_matched_state", 32'(dbg_state),   32'(ST_FIRST));
    chk("sel_matched_face",  32'(bus.face_up), 32'h0000);
    sel(4'd2);
    chk("sel2_face",  32'(bus.face_up),    32'h0004);
    chk("sel2_start", 32'(bus.game_start), 32'h0);
    sel(4'd2);
    chk("reselect_state", 32'(dbg_state),   32'(ST_SECOND));
    chk("reselect_face",  32'(bus.face_up), 32'h0004);
    deck_write(4'd2, 3'd7);
    chk("deckwr_state", 32'(dbg_state), 32'(ST_SECOND));

    // Mismatch 2 (pair 1) vs 4 (pair 2) and SHOW hold
    sel(4'd4);
    chk("mm_cmp_face",  32'(bus.face_up), 32'h0014);
    chk("mm_cmp_state", 32'(dbg_state),   32'(ST_COMPARE));
    step();
    chk("mm_show_state", 32'(dbg_state),      32'(ST_SHOW));
    chk("mm_count",      32'(bus.mismatches), 32'h1);
    chk("mm_show_busy",  32'(bus.busy),       32'h1);
    chk("mm_show_face1", 32'(bus.face_up),    32'h0014);
    sel(4'd6);
    chk("mm_show_sel_ignored", 32'(bus.face_up), 32'h0014);
    step();
    chk("mm_show_face3", 32'(bus.face_up), 32'h0014);
    step();
    chk("mm_show_face4", 32'(bus.face_up), 32'h0014);
    chk("mm_show_state4", 32'(dbg_state),  32'(ST_SHOW));
    step();
    chk("mm_expire_face",  32'(bus.face_up), 32'h0000);
    chk("mm_expire_state", 32'(dbg_state),   32'(ST_FIRST));
    chk("mm_expire_busy",  32'(bus.busy),    32'h0);

    // Deck write in SECOND was dropped: 2 and 3 still match
    sel(4'd2);
    sel(4'd3);
    step();
    chk("pair1_match", 32'(bus.matched),     32'h000F);
    chk("pair1_pairs", 32'(bus.pairs_found), 32'h2);
    chk("pair1_mism",  32'(bus.mismatches),  32'h1);

    // Remaining pairs; game_end only on the eighth
    for (int p = 2; p < 8; p++) begin
      sel(4'(2 * p));
      chk("rest_start_a", 32'(bus.game_start), 32'h0);
      sel(4'(2 * p + 1));
      chk("rest_end_sel", 32'(bus.game_end), 32'h0);
      step();
      chk("rest_pairs", 32'(bus.pairs_found), 32'(p + 1));
      chk("rest_end",   32'(bus.game_end),    32'(p == 7));
    end
    chk("done_match", 32'(bus.matched), 32'hFFFF);
    chk("done_state", 32'(dbg_state),   32'(ST_DONE));
    step();
    chk("end_one_cycle", 32'(bus.game_end), 32'h0);
    sel(4'd0);
    chk("done_sel_start", 32'(bus.game_start), 32'h0);
    chk("done_sel_state", 32'(dbg_state),      32'(ST_DONE));

    // new_game, then new_game coincident with the second selection
    bus.new_game = 1'b1;
    step();
    bus.new_game = 1'b0;
    chk_idle_zero("newgame1");
    sel(4'd0);
    chk("ng_sel0_start", 32'(bus.game_start), 32'h1);
    bus.new_game = 1'b1;
    sel(4'd1);
    bus.new_game = 1'b0;
    chk_idle_zero("newgame_coincident");
    sel(4'd5);
    chk("fresh_start", 32'(bus.game_start), 32'h1);
    chk("fresh_face",  32'(bus.face_up),    32'h0020);

    // Mismatch counter saturation
    bus.new_game = 1'b1;
    step();
    bus.new_game = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      do_mismatch(4'd0, 4'd2);
      chk("sat_count", 32'(bus.mismatches), 32'((k > 255) ? 255 : k));
    end
    chk("sat_final_face",  32'(bus.face_up), 32'h0000);
    chk("sat_final_state", 32'(dbg_state),   32'(ST_FIRST));

    // Reset mid-SHOW
    sel(4'd0);
    sel(4'd2);
    step();
    step();
    chk("pre_reset_state", 32'(dbg_state), 32'(ST_SHOW));
    reset = 1'b0;
    step();
    chk_idle_zero("reset_mid_show");
    reset = 1'b1;
    step();

    // Deck survives reset
    sel(4'd0);
    chk("post_reset_start", 32'(bus.game_start), 32'h1);
    sel(4'd1);
    step();
    chk("post_reset_match", 32'(bus.matched),     32'h0003);
    chk("post_reset_pairs", 32'(bus.pairs_found), 32'h1);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
